// File: rtl/aibcr3_rxdig_pkg.sv
// Shared types and constants for the AIB RX deserializer.
// Holds the alignment FSM state encoding and training parameters.
package aibcr3_rxdig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_LOCKED,
    ST_FAIL
  } rx_state_e;

  localparam logic [1:0] TRAIN_PATTERN  = 2'b01;
  localparam logic [3:0] LOCK_MATCH_CNT = 4'd8;
  localparam logic [3:0] MAX_SLIP       = 4'd15;

endpackage

// File: rtl/aibcr3_rxdig_align.sv
// Alignment FSM: trains the even/odd pairing against a fixed pattern.
// Emits a one-cycle bitslip and lock/fail status.
module aibcr3_rxdig_align
  import aibcr3_rxdig_pkg::*;
(
  input  logic      iclk,
  input  logic      irst,
  input  logic      active,
  input  logic      itrain_en,
  input  logic      pair_done,
  input  logic [1:0] pair_bits,
  output rx_state_e state,
  output logic      bitslip,
  output logic      olock,
  output logic      ofail
);

  logic [3:0] match_cnt;
  logic [3:0] slip_cnt;
  logic       train_q;
  logic [3:0] match_nxt;
  logic       train_rise;

  assign match_nxt  = (match_cnt == 4'hF) ? match_cnt
                                          : match_cnt + 4'd1;
  assign train_rise = itrain_en & ~train_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      state     <= ST_IDLE;
      match_cnt <= '0;
      slip_cnt  <= '0;
      train_q   <= 1'b0;
      bitslip   <= 1'b0;
      olock     <= 1'b0;
      ofail     <= 1'b0;
    end else begin
      train_q <= itrain_en;
      bitslip <= 1'b0;
      if (!active) begin
        state     <= ST_IDLE;
        match_cnt <= '0;
        slip_cnt  <= '0;
        olock     <= 1'b0;
        ofail     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (itrain_en) begin
              state     <= ST_TRAIN;
              match_cnt <= '0;
              slip_cnt  <= '0;
            end
          end
          ST_TRAIN: begin
            if (pair_done) begin
              if (pair_bits == TRAIN_PATTERN) begin
                match_cnt <= match_nxt;
                if (match_nxt >= LOCK_MATCH_CNT) begin
                  state <= ST_LOCKED;
                  olock <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
                // Exhausted slips end training instead of slipping again
                if (slip_cnt == MAX_SLIP) begin
                  state <= ST_FAIL;
                  ofail <= 1'b1;
                end else begin
                  slip_cnt <= slip_cnt + 4'd1;
                  bitslip  <= 1'b1;
                end
              end
            end
          end
          ST_LOCKED, ST_FAIL: begin
            if (train_rise) begin
              state     <= ST_TRAIN;
              match_cnt <= '0;
              slip_cnt  <= '0;
              olock     <= 1'b0;
              ofail     <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/aibcr3_rxdig_deser.sv
// AIB RX digital deserializer: pairs serial bits into even/odd outputs.
// Includes loopback select, registered bypass and alignment training.
module aibcr3_rxdig_deser
  import aibcr3_rxdig_pkg::*;
(
  input  logic iclk,
  input  logic irst,
  input  logic rx_dat_in,
  input  logic rx_en,
  input  logic ipadrstb,
  input  logic iddrctrl,
  input  logic idataselb,
  input  logic ilpbk_en,
  input  logic ilpbk_dat,
  input  logic itrain_en,
  output logic odat0,
  output logic odat1,
  output logic odat_vld,
  output logic oasync_data,
  output logic olock,
  output logic ofail
);

  rx_state_e state;
  logic      sin;
  logic      active;
  logic      phase_q;
  logic      hold_q;
  logic      pair_done;
  logic      bitslip;
  logic      vld_ok;

  assign sin       = ilpbk_en ? ilpbk_dat : rx_dat_in;
  assign active    = rx_en & ipadrstb;
  assign pair_done = active & phase_q;
  assign vld_ok    = idataselb &
                     ((state == ST_IDLE) | (state == ST_LOCKED));

  aibcr3_rxdig_align u_align (
    .iclk      (iclk),
    .irst      (irst),
    .active    (active),
    .itrain_en (itrain_en),
    .pair_done (pair_done),
    .pair_bits ({sin, hold_q}),
    .state     (state),
    .bitslip   (bitslip),
    .olock     (olock),
    .ofail     (ofail)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      phase_q     <= 1'b0;
      hold_q      <= 1'b0;
      odat0       <= 1'b0;
      odat1       <= 1'b0;
      odat_vld    <= 1'b0;
      oasync_data <= 1'b0;
    end else begin
      oasync_data <= sin;
      odat_vld    <= 1'b0;
      // A bitslip freezes the phase for one cycle to shift pairing by one
      if (!active)
        phase_q <= 1'b0;
      else if (!bitslip)
        phase_q <= ~phase_q;
      if (active && !phase_q)
        hold_q <= sin;
      if (pair_done && vld_ok) begin
        odat0    <= hold_q;
        odat1    <= iddrctrl ? sin : hold_q;
        odat_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aibcr3_rxdig_deser.sv
// Scoreboard bench for aibcr3_rxdig_deser.
// Directed vectors push expected pairs; a monitor checks each vld.
module tb_aibcr3_rxdig_deser;

  logic iclk = 1'b0;
  logic irst, rx_dat_in, rx_en, ipadrstb, iddrctrl, idataselb;
  logic ilpbk_en, ilpbk_dat, itrain_en;
  logic odat0, odat1, odat_vld, oasync_data, olock, ofail;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  aibcr3_rxdig_deser dut (
    .iclk        (iclk),
    .irst        (irst),
    .rx_dat_in   (rx_dat_in),
    .rx_en       (rx_en),
    .ipadrstb    (ipadrstb),
    .iddrctrl    (iddrctrl),
    .idataselb   (idataselb),
    .ilpbk_en    (ilpbk_en),
    .ilpbk_dat   (ilpbk_dat),
    .itrain_en   (itrain_en),
    .odat0       (odat0),
    .odat1       (odat1),
    .odat_vld    (odat_vld),
    .oasync_data (oasync_data),
    .olock       (olock),
    .ofail       (ofail)
  );

  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic b);
    rx_dat_in = b;
    tick();
  endtask

  task automatic clear_phase();
    rx_en = 1'b0;
    tick();
    rx_en = 1'b1;
  endtask

  always @(negedge iclk) begin
    if (!irst && odat_vld) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_vld: got %b%b expected no vld",
                 odat0, odat1);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({odat0, odat1} !== e) begin
          n_fail++;
          $display("FAIL pair: got %b%b expected %b",
                   odat0, odat1, e);
        end
      end
    end
  end

  initial begin
    int cyc;
    irst = 1'b1; rx_dat_in = 1'b0; rx_en = 1'b1; ipadrstb = 1'b1;
    iddrctrl = 1'b1; idataselb = 1'b1; ilpbk_en = 1'b0;
    ilpbk_dat = 1'b0; itrain_en = 1'b0;
    tick(); tick();
    chk("reset_outs",
        {odat0, odat1, odat_vld, oasync_data, olock, ofail}, 0);
    irst = 1'b0;

    // DDR basic
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    send(1); send(0);
    chk("ddr_vld_lat1", odat_vld, 1);
    send(0);
    chk("ddr_vld_gap", odat_vld, 0);
    send(1);
    chk("ddr_vld_lat2", odat_vld, 1);
    idataselb = 1'b0;
    tick(); tick();

    // Active drop coincides with pair completion
    clear_phase();
    idataselb = 1'b1;
    send(1);
    rx_en = 1'b0;
    send(0);
    chk("drop_no_vld", odat_vld, 0);
    chk("drop_hold", {odat0, odat1}, 2'b01);

    // SDR
    rx_en = 1'b1; iddrctrl = 1'b0;
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    send(1); send(0); send(0); send(1);
    idataselb = 1'b0;
    tick(); tick();

    // Training, misaligned by one bit
    clear_phase();
    iddrctrl = 1'b1; idataselb = 1'b1; itrain_en = 1'b1;
    cyc = 0;
    while (!olock && cyc < 40) begin
      send(logic'(cyc % 2));
      cyc++;
    end
    chk("train_lock", olock, 1);
    chk("train_lock_cycles", cyc, 19);
    chk("train_nofail", ofail, 0);
    exp_q.push_back(2'b10);
    send(1); send(0);
    idataselb = 1'b0;
    ipadrstb = 1'b0;
    tick();
    chk("padrst_unlock", olock, 0);
    ipadrstb = 1'b1;

    // Training failure with all ones
    cyc = 0;
    while (!ofail && cyc < 80) begin
      send(1);
      cyc++;
    end
    chk("train_fail", ofail, 1);
    chk("train_fail_cycles", cyc, 47);
    chk("fail_nolock", olock, 0);
    itrain_en = 1'b0;
    tick();
    chk("fail_held", ofail, 1);
    itrain_en = 1'b1;
    tick();
    chk("retrain_clears_fail", ofail, 0);

    // Loopback and bypass
    ilpbk_en = 1'b1; ilpbk_dat = 1'b1; rx_dat_in = 1'b0;
    itrain_en = 1'b0;
    tick();
    chk("lpbk_async", oasync_data, 1);
    chk("lpbk_no_vld", odat_vld, 0);
    ilpbk_en = 1'b0;
    tick();
    chk("rx_async", oasync_data, 0);

    // Reset in TRAIN with match count 5
    clear_phase();
    itrain_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1); send(0);
    end
    chk("mid_train_unlocked", olock, 0);
    rx_dat_in = 1'b1; irst = 1'b1;
    itrain_en = 1'b0; idataselb = 1'b1;
    tick();
    chk("midrst_outs",
        {odat0, odat1, odat_vld, oasync_data, olock, ofail}, 0);
    irst = 1'b0;
    exp_q.push_back(2'b11);
    send(1); send(1);
    chk("post_rst_idle_vld", odat_vld, 1);
    idataselb = 1'b0;
    tick(); tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
